// File: rtl/rca32_pkg.sv
// Shared types and helpers for the ripple-carry-adder operation sequencer.
package rca32_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Signed overflow of a + b (subtract already folded into b as ~b with cin=1).
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/rca32_result_reg.sv
// Capture register for the adder result plus carry, overflow and zero flags.
module rca32_result_reg
    import rca32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              a_msb,
    input  logic              b_msb,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              out_zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else if (capture) begin
            out_sum  <= add_sum;
            out_cout <= add_cout;
            out_ovf  <= signed_ovf(a_msb, b_msb, add_sum[DATA_W-1]);
            out_zero <= (add_sum == '0);
        end
    end

endmodule

// File: rtl/rca32_op_sequencer.sv
// Request front-end and result capture around an external 32-bit ripple carry adder.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// SETTLE | operands on the adder, counting down the ripple settle time
// HOLD   | result valid, held until the consumer takes it
module rca32_op_sequencer
    import rca32_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_sub,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              out_zero
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = SETTLE;
            SETTLE:  if (capture) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = accept ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            SETTLE:  capture  = (cnt == '0);
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        // Nothing is accepted while reset is held, even though state already reads IDLE.
        in_ready = in_ready & ~rst;
    end

    assign accept = in_valid & in_ready;

    // Operands stay on the adder from accept to the next accept so its outputs never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            add_a   <= in_a;
            add_b   <= in_sub ? ~in_b : in_b;
            add_cin <= in_sub | in_cin;
            cnt     <= CNT_LOAD;
        end else if (state == SETTLE && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    rca32_result_reg u_result (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .a_msb    (add_a[DATA_W-1]),
        .b_msb    (add_b[DATA_W-1]),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
    );

endmodule

// File: tb/tb_rca32_op_sequencer.sv
// Scoreboard bench: two sequencers (settle 4 and settle 1) each driving a behavioural adder.
module tb_rca32_op_sequencer;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    logic        in_valid4, in_ready4, in_cin4, in_sub4, add_cin4, add_cout4;
    logic [31:0] in_a4, in_b4, add_a4, add_b4, add_sum4, out_sum4;
    logic        out_valid4, out_ready4, out_cout4, out_ovf4, out_zero4;

    logic        in_valid1, in_ready1, in_cin1, in_sub1, add_cin1, add_cout1;
    logic [31:0] in_a1, in_b1, add_a1, add_b1, add_sum1, out_sum1;
    logic        out_valid1, out_ready1, out_cout1, out_ovf1, out_zero1;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    bit   pv4, pv1;

    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + 33'(add_cin4);
    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + 33'(add_cin1);

    rca32_op_sequencer #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4), .in_sub(in_sub4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sum(out_sum4), .out_cout(out_cout4), .out_ovf(out_ovf4), .out_zero(out_zero4)
    );

    rca32_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .in_sub(in_sub1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1), .out_zero(out_zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input int acc);
        exp_t        r;
        logic [32:0] t;
        if (sub) begin
            t      = {1'b0, a} - {1'b0, b};
            r.sum  = t[31:0];
            r.cout = (a >= b);
            r.ovf  = (a[31] != b[31]) && (r.sum[31] != a[31]);
        end else begin
            t      = {1'b0, a} + {1'b0, b} + 33'(cin);
            r.sum  = t[31:0];
            r.cout = t[32];
            r.ovf  = (a[31] == b[31]) && (r.sum[31] != a[31]);
        end
        r.zero = (r.sum == 32'd0);
        r.acc  = acc;
        return r;
    endfunction

    // Caller is positioned at a negedge; returns just after the accepting edge.
    task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int w;
        in_a4 = a; in_b4 = b; in_cin4 = cin; in_sub4 = sub; in_valid4 = 1'b1;
        #1;
        w = 0;
        while (!in_ready4 && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        check("op4_ready", 64'(in_ready4), 64'(1));
        q4.push_back(model(a, b, cin, sub, cyc + 1));
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q4.size() > 0 || q1.size() > 0) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(q4.size() + q1.size()), 64'(0));
    endtask

    // Monitors sample 2 time units after the falling edge so bench drives have settled.
    always begin
        @(negedge clk); #2;
        if (rst) begin
            pv4 = 1'b0;
        end else begin
            if (out_valid4 && !pv4 && q4.size() > 0)
                check("lat4", 64'(cyc - q4[0].acc), 64'(4));
            if (out_valid4 && out_ready4) begin
                check("sb4_nonempty", 64'(q4.size() > 0), 64'(1));
                if (q4.size() > 0) begin
                    e4 = q4.pop_front();
                    check("sum4",  64'(out_sum4),  64'(e4.sum));
                    check("cout4", 64'(out_cout4), 64'(e4.cout));
                    check("ovf4",  64'(out_ovf4),  64'(e4.ovf));
                    check("zero4", 64'(out_zero4), 64'(e4.zero));
                end
            end
            pv4 = out_valid4;
        end
    end

    always begin
        @(negedge clk); #2;
        if (rst) begin
            pv1 = 1'b0;
        end else begin
            if (out_valid1 && !pv1 && q1.size() > 0)
                check("lat1", 64'(cyc - q1[0].acc), 64'(1));
            if (out_valid1 && out_ready1) begin
                check("sb1_nonempty", 64'(q1.size() > 0), 64'(1));
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    check("sum1",  64'(out_sum1),  64'(e1.sum));
                    check("cout1", 64'(out_cout1), 64'(e1.cout));
                    check("ovf1",  64'(out_ovf1),  64'(e1.ovf));
                    check("zero1", 64'(out_zero1), 64'(e1.zero));
                end
            end
            pv1 = out_valid1;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          w;
        int          prev_acc;
        logic [31:0] ra, rb;
        logic        rc, rs;

        checks = 0; errors = 0;
        rst = 1'b1;
        in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_cin4 = 0; in_sub4 = 0; out_ready4 = 1;
        in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_cin1 = 0; in_sub1 = 0; out_ready1 = 1;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready4),  64'(0));
        check("rst_out_valid", 64'(out_valid4), 64'(0));
        check("rst_add_a",     64'(add_a4),     64'(0));
        check("rst_add_b",     64'(add_b4),     64'(0));
        check("rst_out_sum",   64'(out_sum4),   64'(0));
        check("rst_in_ready1", 64'(in_ready1),  64'(0));
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready4), 64'(1));

        // Wrap to zero with carry out
        @(negedge clk);
        op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drain();

        // 5 - 7: adder sees inverted b and forced carry
        @(negedge clk);
        op4(32'd5, 32'd7, 1'b0, 1'b1);
        check("sub_add_a",   64'(add_a4),   64'(32'd5));
        check("sub_add_b",   64'(add_b4),   64'(32'hFFFF_FFF8));
        check("sub_add_cin", 64'(add_cin4), 64'(1));
        drain();

        @(negedge clk);
        op4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        op4(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        drain();
        @(negedge clk);
        op4(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        drain();

        // Backpressure for 10 cycles with a pending request, then same-edge handoff
        out_ready4 = 1'b0;
        @(negedge clk);
        op4(32'd10, 32'd20, 1'b0, 1'b0);
        w = 0;
        while (!out_valid4 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid", 64'(out_valid4), 64'(1));
        in_a4 = 32'd100; in_b4 = 32'd1; in_cin4 = 1'b0; in_sub4 = 1'b1; in_valid4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid4), 64'(1));
            check("bp_out_sum",   64'(out_sum4),   64'(32'd30));
            check("bp_in_ready",  64'(in_ready4),  64'(0));
            check("bp_add_a",     64'(add_a4),     64'(32'd10));
            check("bp_add_b",     64'(add_b4),     64'(32'd20));
        end
        out_ready4 = 1'b1;
        op4(32'd100, 32'd1, 1'b0, 1'b1);
        check("handoff_add_a", 64'(add_a4), 64'(32'd100));
        drain();

        // Asynchronous reset two cycles into settle drops the operation
        @(negedge clk);
        op4(32'hABCD_0000, 32'h0000_1234, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_add_a",     64'(add_a4),     64'(0));
        check("arst_add_b",     64'(add_b4),     64'(0));
        check("arst_add_cin",   64'(add_cin4),   64'(0));
        check("arst_out_sum",   64'(out_sum4),   64'(0));
        check("arst_out_cout",  64'(out_cout4),  64'(0));
        check("arst_out_ovf",   64'(out_ovf4),   64'(0));
        check("arst_out_zero",  64'(out_zero4),  64'(0));
        check("arst_out_valid", 64'(out_valid4), 64'(0));
        check("arst_in_ready",  64'(in_ready4),  64'(0));
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready4), 64'(1));
        repeat (8) @(negedge clk);
        check("post_rst_no_valid", 64'(out_valid4), 64'(0));
        op4(32'hCAFE_0000, 32'h0000_BEEF, 1'b1, 1'b0);
        drain();

        // Settle of one: back-to-back random ops, one accept every 2 cycles
        prev_acc = 0;
        for (int n = 0; n < 100; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if (n == 0) @(negedge clk);
            in_a1 = ra; in_b1 = rb; in_cin1 = rc; in_sub1 = rs; in_valid1 = 1'b1;
            #1;
            w = 0;
            while (!in_ready1 && w < 20) begin
                @(negedge clk); #1;
                w++;
            end
            check("t6_ready", 64'(in_ready1), 64'(1));
            q1.push_back(model(ra, rb, rc, rs, cyc + 1));
            if (n > 0) check("t6_period", 64'(cyc + 1 - prev_acc), 64'(2));
            prev_acc = cyc + 1;
            @(negedge clk);
        end
        in_valid1 = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
